// File: rtl/reg_shift_pair.sv
`default_nettype none
// ============================================================================
//  Module   : reg_shift_pair
//  Purpose  : Two storage primitives that share one clock and one reset.
//             Path A is a parallel-load register: q follows d one clock later.
//             Path B is a serial-in/parallel-out shift register. It is fed
//             from d[SHIFT_TAP]; new bits enter the LSB and move toward the MSB.
//  Ports    : clk  - system clock; all state changes on the rising edge
//             rst  - asynchronous, active-high reset; clears q and sq at once
//             d    - WIDTH-bit data input shared by both paths
//             q    - WIDTH-bit parallel register output (registered)
//             sq   - WIDTH-bit shift register contents (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_shift_pair #(
  parameter int WIDTH     = 8,
  parameter int SHIFT_TAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] sq
);

  logic [WIDTH-1:0] par_q;
  logic [WIDTH-1:0] par_d;
  logic [WIDTH-1:0] shf_q;
  logic [WIDTH-1:0] shf_d;

  // The parallel path reloads every cycle because it has no enable.
  // The shift path drops its MSB and takes the tap bit in at the LSB.
  always_comb begin
    par_d = d;
    shf_d = {shf_q[WIDTH-2:0], d[SHIFT_TAP]};
  end

  // Asynchronous clear: both paths go to zero as soon as rst rises and
  // stay there while it is high. The first edge after release is a normal
  // update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= '0;
      shf_q <= '0;
    end else begin
      par_q <= par_d;
      shf_q <= shf_d;
    end
  end

  assign q  = par_q;
  assign sq = shf_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_shift_pair.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_shift_pair
//  Purpose  : Directed scoreboard bench for reg_shift_pair. The stimulus
//             pushes hand-computed expected {q, sq} pairs into a queue and
//             raises a sample event. A monitor pops each entry and compares it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_shift_pair;

  localparam int WIDTH = 8;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] sq;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] sq;

  exp_t exp_q[$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  reg_shift_pair #(
    .WIDTH    (WIDTH),
    .SHIFT_TAP(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .d  (d),
    .q  (q),
    .sq (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each time an output is presented, pop one expectation and compare.
  initial begin
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL unexpected_sample: no expectation queued, q=%02h sq=%02h", q, sq);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (q !== e.q) begin
          failures++;
          $display("FAIL %s.q: got %02h expected %02h", e.name, q, e.q);
        end
        checks++;
        if (sq !== e.sq) begin
          failures++;
          $display("FAIL %s.sq: got %02h expected %02h", e.name, sq, e.sq);
        end
      end
    end
  end

  // Queue an expectation and have the monitor check it against the live outputs.
  task automatic expect_now(input string nm, input logic [WIDTH-1:0] eq,
                            input logic [WIDTH-1:0] esq);
    exp_t e;
    e.name = nm;
    e.q    = eq;
    e.sq   = esq;
    exp_q.push_back(e);
    ->sample_ev;
    #0;
  endtask

  // Drive d, take one rising edge, then sample 1 ns later.
  task automatic step(input string nm, input logic [WIDTH-1:0] dv,
                      input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] esq);
    d = dv;
    @(posedge clk);
    #1;
    expect_now(nm, eq, esq);
  endtask

  // Shift-pattern vectors. The bit0 sequence is 1,0,1,1,0,0,0,1 and the upper
  // bits are arbitrary.
  logic [WIDTH-1:0] shp_d  [8] = '{8'h81, 8'h40, 8'h23, 8'hF1, 8'h0E, 8'h9C, 8'h00, 8'h77};
  logic [WIDTH-1:0] shp_sq [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB1};
  logic [WIDTH-1:0] fill_sq[8] = '{8'hC5, 8'h8B, 8'h17, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF};
  logic [WIDTH-1:0] drain_sq[8] = '{8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00};

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d   = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset_state", 8'h00, 8'h00);
    #2 rst = 1'b0;

    // Parallel load. These edges also preload nonzero state for the async reset test.
    step("load_A5", 8'hA5, 8'hA5, 8'h01);
    step("load_3C", 8'h3C, 8'h3C, 8'h02);
    step("load_FF", 8'hFF, 8'hFF, 8'h05);

    // Async reset mid-cycle with no clock edge, then held across 3 edges.
    #2 rst = 1'b1;
    #1 expect_now("async_reset", 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step("reset_hold", 8'hFF, 8'h00, 8'h00);
    #2 rst = 1'b0;

    // Shift pattern from a cleared register.
    for (int i = 0; i < 8; i++) step("shift_pattern", shp_d[i], shp_d[i], shp_sq[i]);

    // The MSB of 0xB1 is discarded.
    step("overflow", 8'h10, 8'h10, 8'h62);

    // Fill with ones, then hold d=0xFE: upper bits must not reach sq.
    for (int i = 0; i < 8; i++) step("fill_ones", 8'h01, 8'h01, fill_sq[i]);
    step("tap_iso_0", 8'hFE, 8'hFE, 8'hFE);
    for (int i = 0; i < 7; i++) step("tap_iso", 8'hFE, 8'hFE, drain_sq[i]);

    // Reset mid-stream, then recovery.
    step("stream_37", 8'h37, 8'h37, 8'h01);
    step("stream_37b", 8'h37, 8'h37, 8'h03);
    step("stream_C8", 8'hC8, 8'hC8, 8'h06);
    #2 rst = 1'b1;
    #1 expect_now("midstream_reset", 8'h00, 8'h00);
    #4 rst = 1'b0;
    #1 expect_now("after_release", 8'h00, 8'h00);
    step("recover_6B", 8'h6B, 8'h6B, 8'h01);
    step("recover_6A", 8'h6A, 8'h6A, 8'h02);

    #2;
    if (exp_q.size() != 0) begin
      failures += exp_q.size();
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_shift_pair.md
Name: reg_shift_pair

Overview:
- Storage primitive pair sharing one clock and one reset.
- Path A is an 8-bit parallel load register (q follows d one clock later).
- Path B is an 8-bit serial-in/parallel-out shift register fed from d[0].
- Used as a basic storage/serialisation element behind datapath inputs.

Parameters:
- WIDTH, 8, data width of d, q and sq (must be >= 2).
- SHIFT_TAP, 0, index of the d bit shifted into path B (0 <= SHIFT_TAP < WIDTH).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  data input shared by both paths.
- q  output  WIDTH  parallel register output (registered).
- sq  output  WIDTH  shift register contents (registered).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst); the polarity and synchronicity here are fixed.
- Reset:
  - rst=1 forces q=0 and sq=0 immediately, without waiting for a clock edge.
  - Both outputs hold 0 for as long as rst stays high; clock edges are ignored.
- Reset release:
  - The first rising clk edge with rst=0 performs a normal update.
  - There is no extra dead cycle.
- Path A: on each rising clk edge with rst=0, q <= d.
  - Latency is one clock.
  - There is no enable; q reloads every cycle.
- Path B: on each rising clk edge with rst=0, sq <= {sq[WIDTH-2:0], d[SHIFT_TAP]}.
  - The new bit enters the LSB and all bits move one position toward the MSB.
  - sq[WIDTH-1] is discarded each cycle.
  - A bit presented at d[SHIFT_TAP] appears at sq[k] after k+1 clocks and leaves after WIDTH+1 clocks.
- Both paths sample the same d on the same edge; there is no combinational path from d to any output.
- Reset mid-operation:
  - Asserting rst at any time, including between clock edges, clears both registers at once.
  - Shifted history is lost.
- Width rules:
  - No arithmetic.
  - Bits of d other than SHIFT_TAP have no effect on sq.
- X-handling: after reset, outputs must never be X provided d is not X.
- Both paths are plain flip-flops; there are no latches and no gated clocks.

Test Plan:
- Async reset: q and sq preloaded with nonzero values; raise rst mid-cycle with no clk edge -> q=0x00 and sq=0x00 within the same delta/time step; both stay 0 across 3 clk edges while rst=1.
- Parallel load: rst=0; drive d=0xA5, then 0x3C, then 0xFF on successive edges -> after each edge q equals the d sampled at that edge (0xA5, 0x3C, 0xFF), never the next value.
- Shift pattern: from reset, drive d[0] as 1,0,1,1,0,0,0,1 over 8 edges -> sq = 0x01, 0x02, 0x05, 0x0B, 0x16, 0x2C, 0x58, 0xB1.
- Overflow/discard: after sq=0xB1, apply 1 more edge with d[0]=0 -> sq=0x62 (MSB 1 dropped).
- Tap isolation: hold d=0xFE (bit0=0) for 8 edges after sq=0xFF -> sq goes to 0x00 while q=0xFE.
- Reset mid-stream and recovery: during random d every other cycle, assert rst for 5 ns between edges, then release -> both outputs 0 at once; the first edge after release loads q=d and sq=0x00|d[0].
